// File: rtl/score_keeper_multi.sv
// score_keeper_multi
//   Accumulates a BCD score for one selected mini-game out of NUM_GAMES channels.
//   Supports an optional miss penalty, saturation at all-9s and a floor at zero.
//   A per-game best-score table is updated when a round stops.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          synchronous reset, active-high
//   game_en      one-hot game select, sampled on start
//   start        pulse: clear score, latch game, run
//   stop         pulse: end round, update best table (wins over start)
//   point_pulse  per-game point pulses
//   miss_pulse   per-game miss pulses
//   best_sel     index of the best-score entry to read
//   score_bcd    current score, digit 0 in [3:0]
//   best_bcd     best[best_sel], zero when best_sel is out of range
//   state        0=IDLE 1=RUN 2=DONE
//   new_record   last stop raised best[active]
//   sel_err      last start saw a non-one-hot game_en
module score_keeper_multi #(
  parameter int unsigned NUM_GAMES  = 6,
  parameter int unsigned DIGITS     = 3,
  parameter bit          PENALTY_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_GAMES-1:0]   game_en,
  input  logic                   start,
  input  logic                   stop,
  input  logic [NUM_GAMES-1:0]   point_pulse,
  input  logic [NUM_GAMES-1:0]   miss_pulse,
  input  logic [2:0]             best_sel,
  output logic [4*DIGITS-1:0]    score_bcd,
  output logic [4*DIGITS-1:0]    best_bcd,
  output logic [1:0]             state,
  output logic                   new_record,
  output logic                   sel_err
);

  localparam int unsigned ScoreW = 4 * DIGITS;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q;
  logic [ScoreW-1:0] score_q;
  logic [ScoreW-1:0] best_q [NUM_GAMES];
  logic [2:0]        active_q;
  logic              new_record_q;
  logic              sel_err_q;

  logic              sel_onehot;
  logic [2:0]        sel_idx;
  logic              pt;
  logic              ms;
  logic [ScoreW-1:0] score_inc;
  logic [ScoreW-1:0] score_dec;
  logic [ScoreW-1:0] all_nines;
  logic              carry;
  logic              borrow;

  // Game select decode.
  always_comb begin
    sel_onehot = ($countones(game_en) == 1);
    sel_idx    = '0;
    for (int unsigned i = 0; i < NUM_GAMES; i++) begin
      if (game_en[i]) sel_idx = 3'(i);
    end
  end

  assign pt = point_pulse[active_q];
  assign ms = miss_pulse[active_q] & PENALTY_EN;

  // Decimal increment/decrement; digits ripple only while a carry/borrow is pending, so the
  // result is always a valid BCD value. All-9s and zero are held.
  always_comb begin
    all_nines = '0;
    score_inc = score_q;
    score_dec = score_q;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      all_nines[4*d +: 4] = 4'd9;
      if (carry) begin
        if (score_q[4*d +: 4] == 4'd9) begin
          score_inc[4*d +: 4] = 4'd0;
        end else begin
          score_inc[4*d +: 4] = score_q[4*d +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (score_q[4*d +: 4] == 4'd0) begin
          score_dec[4*d +: 4] = 4'd9;
        end else begin
          score_dec[4*d +: 4] = score_q[4*d +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    if (score_q == all_nines) score_inc = score_q;
    if (score_q == '0)        score_dec = score_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      score_q      <= '0;
      active_q     <= '0;
      new_record_q <= 1'b0;
      sel_err_q    <= 1'b0;
      for (int unsigned g = 0; g < NUM_GAMES; g++) best_q[g] <= '0;
    end else begin
      case (state_q)
        StRun: begin
          if (stop) begin
            state_q <= StDone;
            // Packed BCD orders the same as its decimal value.
            if (score_q > best_q[active_q]) begin
              best_q[active_q] <= score_q;
              new_record_q     <= 1'b1;
            end else begin
              new_record_q     <= 1'b0;
            end
          end else if (start) begin
            // Restart; a bad select keeps the current round running untouched.
            if (sel_onehot) begin
              active_q     <= sel_idx;
              score_q      <= '0;
              new_record_q <= 1'b0;
              sel_err_q    <= 1'b0;
            end else begin
              sel_err_q    <= 1'b1;
            end
          end else if (pt && !ms) begin
            score_q <= score_inc;
          end else if (ms && !pt) begin
            score_q <= score_dec;
          end
        end
        default: begin
          if (start) begin
            if (sel_onehot) begin
              active_q     <= sel_idx;
              score_q      <= '0;
              new_record_q <= 1'b0;
              sel_err_q    <= 1'b0;
              state_q      <= StRun;
            end else begin
              sel_err_q    <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    best_bcd = '0;
    if (32'(best_sel) < NUM_GAMES) best_bcd = best_q[best_sel];
  end

  assign score_bcd  = score_q;
  assign state      = state_q;
  assign new_record = new_record_q;
  assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_score_keeper_multi.sv
module tb_score_keeper_multi;

  localparam int NG  = 6;
  localparam int MAX = 999;

  logic          clk;
  logic          rst;
  logic [NG-1:0] game_en;
  logic          start;
  logic          stop;
  logic [NG-1:0] point_pulse;
  logic [NG-1:0] miss_pulse;
  logic [2:0]    best_sel;

  logic [11:0] score_bcd, score_bcd_np, best_bcd, best_bcd_np;
  logic [1:0]  state, state_np;
  logic        new_record, new_record_np, sel_err, sel_err_np;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: index 0 has penalties, index 1 ignores misses.
  int m_state;
  int m_active;
  bit m_serr;
  int m_score [2];
  int m_best  [2][8];
  bit m_nr    [2];

  score_keeper_multi #(.NUM_GAMES(6), .DIGITS(3), .PENALTY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .game_en(game_en), .start(start), .stop(stop),
    .point_pulse(point_pulse), .miss_pulse(miss_pulse), .best_sel(best_sel),
    .score_bcd(score_bcd), .best_bcd(best_bcd), .state(state),
    .new_record(new_record), .sel_err(sel_err)
  );

  score_keeper_multi #(.NUM_GAMES(6), .DIGITS(3), .PENALTY_EN(1'b0)) dut_np (
    .clk(clk), .rst(rst), .game_en(game_en), .start(start), .stop(stop),
    .point_pulse(point_pulse), .miss_pulse(miss_pulse), .best_sel(best_sel),
    .score_bcd(score_bcd_np), .best_bcd(best_bcd_np), .state(state_np),
    .new_record(new_record_np), .sel_err(sel_err_np)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_start(input bit oh, input int idx);
    if (oh) begin
      m_active = idx;
      m_serr   = 1'b0;
      m_state  = 1;
      for (int k = 0; k < 2; k++) begin
        m_score[k] = 0;
        m_nr[k]    = 1'b0;
      end
    end else begin
      m_serr = 1'b1;
    end
  endtask

  task automatic model_step(input logic r, input logic st, input logic sp,
                            input logic [NG-1:0] ge, input logic [NG-1:0] pp,
                            input logic [NG-1:0] mp);
    bit oh;
    int idx;
    bit p, m;
    if (r) begin
      m_state  = 0;
      m_active = 0;
      m_serr   = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_score[k] = 0;
        m_nr[k]    = 1'b0;
        for (int g = 0; g < 8; g++) m_best[k][g] = 0;
      end
      return;
    end
    oh  = ($countones(ge) == 1);
    idx = 0;
    for (int i = 0; i < NG; i++) if (ge[i]) idx = i;
    if (m_state != 1) begin
      if (st) model_start(oh, idx);
    end else if (sp) begin
      m_state = 2;
      for (int k = 0; k < 2; k++) begin
        if (m_score[k] > m_best[k][m_active]) begin
          m_best[k][m_active] = m_score[k];
          m_nr[k] = 1'b1;
        end else begin
          m_nr[k] = 1'b0;
        end
      end
    end else if (st) begin
      model_start(oh, idx);
    end else begin
      for (int k = 0; k < 2; k++) begin
        p = pp[m_active];
        m = mp[m_active] && (k == 0);
        if (p && !m)      m_score[k] = (m_score[k] < MAX) ? m_score[k] + 1 : MAX;
        else if (m && !p) m_score[k] = (m_score[k] > 0) ? m_score[k] - 1 : 0;
      end
    end
  endtask

  task automatic tick(input logic r, input logic st, input logic sp, input logic [NG-1:0] ge,
                      input logic [NG-1:0] pp, input logic [NG-1:0] mp, input logic [2:0] bs);
    rst = r; start = st; stop = sp; game_en = ge;
    point_pulse = pp; miss_pulse = mp; best_sel = bs;
    model_step(r, st, sp, ge, pp, mp);
    @(posedge clk);
    #1;
    check_eq("score", 32'(score_bcd), 32'(to_bcd(m_score[0])));
    check_eq("score_np", 32'(score_bcd_np), 32'(to_bcd(m_score[1])));
    check_eq("state", 32'(state), 32'(m_state));
    check_eq("state_np", 32'(state_np), 32'(m_state));
    check_eq("sel_err", 32'(sel_err), 32'(m_serr));
    check_eq("sel_err_np", 32'(sel_err_np), 32'(m_serr));
    check_eq("new_record", 32'(new_record), 32'(m_nr[0]));
    check_eq("new_record_np", 32'(new_record_np), 32'(m_nr[1]));
    check_eq("best", 32'(best_bcd), (int'(bs) < NG) ? 32'(to_bcd(m_best[0][bs])) : 32'd0);
    check_eq("best_np", 32'(best_bcd_np), (int'(bs) < NG) ? 32'(to_bcd(m_best[1][bs])) : 32'd0);
  endtask

  task automatic points(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 6'b0, 6'b000010, 6'b0, 3'd1);
  endtask

  task automatic go(input logic [NG-1:0] ge);
    tick(0, 1, 0, ge, 6'b0, 6'b0, 3'd1);
  endtask

  initial begin
    logic          r, st, sp;
    logic [NG-1:0] ge, pp, mp;
    rst = 1'b1; start = 0; stop = 0; game_en = '0;
    point_pulse = '0; miss_pulse = '0; best_sel = '0;

    // Reset values, including every best entry.
    for (int s = 0; s < 8; s++) begin
      tick(1, 0, 0, 6'b0, 6'b0, 6'b0, 3'(s));
      check_eq("rst_best", 32'(best_bcd), 32'd0);
    end
    check_eq("rst_score", 32'(score_bcd), 32'h000);
    check_eq("rst_state", 32'(state), 32'd0);

    go(6'b000010);
    points(12);
    check_eq("score_012", 32'(score_bcd), 32'h012);
    points(87);
    check_eq("score_099", 32'(score_bcd), 32'h099);
    points(1);
    check_eq("score_100", 32'(score_bcd), 32'h100);
    tick(0, 0, 0, 6'b0, 6'b0, 6'b000010, 3'd1);
    check_eq("miss_to_099", 32'(score_bcd), 32'h099);
    check_eq("miss_np_100", 32'(score_bcd_np), 32'h100);
    tick(0, 0, 0, 6'b0, 6'b000010, 6'b000010, 3'd1);
    check_eq("pt_and_miss", 32'(score_bcd), 32'h099);
    tick(0, 0, 0, 6'b0, 6'b001000, 6'b0, 3'd1);
    check_eq("other_channel", 32'(score_bcd), 32'h099);

    go(6'b000010);
    points(15);
    tick(0, 0, 1, 6'b0, 6'b0, 6'b0, 3'd1);
    check_eq("stop_state", 32'(state), 32'd2);
    check_eq("best1_015", 32'(best_bcd), 32'h015);
    check_eq("new_rec_1", 32'(new_record), 32'd1);
    go(6'b000010);
    points(10);
    tick(0, 0, 1, 6'b0, 6'b0, 6'b0, 3'd1);
    check_eq("best1_kept", 32'(best_bcd), 32'h015);
    check_eq("new_rec_0", 32'(new_record), 32'd0);

    go(6'b000010);
    points(1000);
    check_eq("saturate", 32'(score_bcd), 32'h999);
    tick(0, 0, 1, 6'b0, 6'b0, 6'b0, 3'd1);
    go(6'b000010);
    tick(0, 0, 0, 6'b0, 6'b0, 6'b000010, 3'd1);
    check_eq("floor", 32'(score_bcd), 32'h000);

    tick(1, 0, 0, 6'b0, 6'b0, 6'b0, 3'd1);
    go(6'b000110);
    check_eq("sel_err_set", 32'(sel_err), 32'd1);
    check_eq("sel_err_idle", 32'(state), 32'd0);

    go(6'b000010);
    points(5);
    tick(0, 1, 1, 6'b000010, 6'b0, 6'b0, 3'd1);
    check_eq("start_stop_state", 32'(state), 32'd2);
    check_eq("start_stop_score", 32'(score_bcd), 32'h005);

    go(6'b000010);
    points(3);
    tick(1, 0, 0, 6'b0, 6'b0, 6'b0, 3'd1);
    check_eq("rst_run_state", 32'(state), 32'd0);
    check_eq("rst_run_score", 32'(score_bcd), 32'h000);
    check_eq("rst_run_best", 32'(best_bcd), 32'h000);

    // Randomised traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      r  = ($urandom_range(0, 499) == 0);
      st = ($urandom_range(0, 39) == 0);
      sp = ($urandom_range(0, 59) == 0);
      ge = ($urandom_range(0, 3) == 0) ? 6'($urandom) : (6'b1 << $urandom_range(0, 5));
      pp = 6'($urandom) & 6'($urandom);
      mp = 6'($urandom) & 6'($urandom) & 6'($urandom);
      tick(r, st, sp, ge, pp, mp, 3'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
